// File: rtl/lif_neuron_array_if.sv
// Update-request and result bus of the LIF neuron bank.
// The producer drives the request side and the bank drives the result side.
interface lif_neuron_array_if #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3,
   parameter int CNT_W = 16
);
   logic                    in_valid;
   logic [IDX_W-1:0]        in_idx;
   logic signed [WIDTH-1:0] in_sum_wx;
   logic [WIDTH-2:0]        theta;
   logic                    reset_mode;

   logic                    out_valid;
   logic [IDX_W-1:0]        out_idx;
   logic signed [WIDTH-1:0] out_u;
   logic                    out_spike;
   logic [CNT_W-1:0]        spike_count;

   modport master (
      output in_valid, in_idx, in_sum_wx, theta, reset_mode,
      input  out_valid, out_idx, out_u, out_spike, spike_count
   );

   modport slave (
      input  in_valid, in_idx, in_sum_wx, theta, reset_mode,
      output out_valid, out_idx, out_u, out_spike, spike_count
   );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons: one leak/integrate/fire
// update per valid beat, result registered one cycle later.
module lif_neuron_array #(
   parameter int WIDTH      = 8,
   parameter int N_NEURONS  = 8,
   parameter int IDX_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
   parameter int BETA_SHIFT = 1,
   parameter int REFRACT    = 2,
   parameter int CNT_W      = 16
) (
   input logic               clk,
   input logic               reset,
   lif_neuron_array_if.slave bus
);
   localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
   localparam logic signed [WIDTH-1:0] U_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] U_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0] u_q    [N_NEURONS];
   logic [RW-1:0]           refr_q [N_NEURONS];
   logic                    out_valid_q;
   logic [IDX_W-1:0]        out_idx_q;
   logic signed [WIDTH-1:0] out_u_q;
   logic                    out_spike_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    idx_ok;
   logic                    upd;
   logic [IDX_W-1:0]        idx;
   logic signed [WIDTH-1:0] cur_u;
   logic signed [WIDTH-1:0] bu;
   logic signed [WIDTH:0]   sum_ext;
   logic signed [WIDTH-1:0] acc;
   logic signed [WIDTH-1:0] theta_s;
   logic [RW-1:0]           cur_refr;
   logic signed [WIDTH-1:0] u_d;
   logic [RW-1:0]           refr_d;
   logic                    spike_d;
   logic [CNT_W-1:0]        cnt_d;

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      idx_ok   = (int'(bus.in_idx) < N_NEURONS);
      upd      = bus.in_valid && idx_ok;
      idx      = idx_ok ? bus.in_idx : '0;
      cur_u    = u_q[idx];
      cur_refr = refr_q[idx];
      bu       = cur_u - (cur_u >>> BETA_SHIFT);
      sum_ext  = {bu[WIDTH-1], bu} + {bus.in_sum_wx[WIDTH-1], bus.in_sum_wx};
      // The two top bits disagree exactly when the WIDTH-bit result overflowed.
      if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
         acc = sum_ext[WIDTH] ? U_MIN : U_MAX;
      end else begin
         acc = sum_ext[WIDTH-1:0];
      end
      theta_s = {1'b0, bus.theta};
      spike_d = 1'b0;
      refr_d  = cur_refr;
      u_d     = acc;
      if (cur_refr != '0) begin
         u_d    = bu;
         refr_d = cur_refr - 1'b1;
      end else if (acc >= theta_s) begin
         spike_d = 1'b1;
         refr_d  = RW'(REFRACT);
         u_d     = bus.reset_mode ? '0 : acc - theta_s;
      end
      cnt_d = cnt_q;
      if (upd && spike_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: the neuron arrays are cleared element by element because every membrane must read zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            u_q[i]    <= '0;
            refr_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_u_q     <= '0;
         out_spike_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= upd;
         cnt_q       <= cnt_d;
         if (upd) begin
            u_q[idx]    <= u_d;
            refr_q[idx] <= refr_d;
            out_idx_q   <= idx;
            out_u_q     <= u_d;
            out_spike_q <= spike_d;
         end
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_idx     = out_idx_q;
   assign bus.out_u       = out_u_q;
   assign bus.out_spike   = out_spike_q;
   assign bus.spike_count = cnt_q;
endmodule
